// File: rtl/ssd_scan_arbiter.sv
// ssd_scan_arbiter: shares the 8-digit seven-segment debug display between the
// UART frame monitor and the register viewer. Digits are time-multiplexed with
// a programmable slot length and a blanked lead-in per slot. Ownership changes
// only at scan-frame boundaries, and each frame is drawn from a 32-bit snapshot
// taken when that frame starts, so a frame never mixes sources or tears.
// Optional feature macro: SSD_SRC_MARK_EN (decimal point on digit 7 marks
// frames owned by the register viewer).
module ssd_scan_arbiter #(
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_req,
  input  logic [31:0] frame_data,
  input  logic        reg_req,
  input  logic [31:0] reg_data,
  output logic        grant_frame,
  output logic        grant_reg,
  output logic        frame_done,
  output logic [7:0]  pos,
  output logic [7:0]  segments
);

  localparam int unsigned PRESC_W = $clog2(CLK_DIV);
  localparam int unsigned DIGIT_W = 3;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DISP_W  = 8;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(7);
  localparam logic [DISP_W-1:0]  DISP_OFF   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCAN_FRAME = 2'd1,
    SCAN_REG   = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [DIGIT_W-1:0]  digit, digit_n;
  logic [PRESC_W-1:0]  presc, presc_n;
  logic [DATA_W-1:0]   snap, snap_n;
  logic                last_reg, last_reg_n;

  logic                grant_frame_n, grant_reg_n, frame_done_n;
  logic [DISP_W-1:0]   pos_n, segments_n;

  logic                tick_c;
  logic                any_req_c;
  logic                pick_frame_c;
  logic [NIB_W-1:0]    nibble_c;

  // Active-low hex glyphs, dp off
  function automatic logic [DISP_W-1:0] decode(input logic [NIB_W-1:0] n);
    logic [DISP_W-1:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Arbitration inputs and the nibble of the digit currently being scanned
  always_comb begin
    tick_c       = (presc == PRESC_LAST);
    any_req_c    = frame_req | reg_req;
    // Frame wins when alone, or on a tie when reg won last time
    pick_frame_c = frame_req & (~reg_req | last_reg);
    nibble_c     = snap[{digit, 2'b00} +: NIB_W];
  end

  // Next-state, datapath and registered-output values
  always_comb begin
    state_n      = state;
    digit_n      = digit;
    presc_n      = presc;
    snap_n       = snap;
    last_reg_n   = last_reg;
    frame_done_n = 1'b0;
    pos_n        = DISP_OFF;
    segments_n   = DISP_OFF;

    case (state)
      IDLE: begin
        if (any_req_c) begin
          state_n    = pick_frame_c ? SCAN_FRAME : SCAN_REG;
          snap_n     = pick_frame_c ? frame_data : reg_data;
          last_reg_n = ~pick_frame_c;
          digit_n    = '0;
          presc_n    = '0;
        end
      end

      default: begin
        // Drive the lit digit once the anti-ghost lead-in has elapsed
        if (presc >= BLANK_END) begin
          pos_n      = ~(8'h01 << digit);
          segments_n = decode(nibble_c);
`ifdef SSD_SRC_MARK_EN
          if (state == SCAN_REG && digit == DIGIT_LAST) begin
            segments_n[7] = 1'b0;
          end
`endif
        end

        if (tick_c) begin
          presc_n = '0;
          digit_n = DIGIT_W'(digit + 1'b1);
          if (digit == DIGIT_LAST) begin
            frame_done_n = 1'b1;
            if (any_req_c) begin
              state_n    = pick_frame_c ? SCAN_FRAME : SCAN_REG;
              snap_n     = pick_frame_c ? frame_data : reg_data;
              last_reg_n = ~pick_frame_c;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          presc_n = PRESC_W'(presc + 1'b1);
        end
      end
    endcase

    // Grants follow the owner state on the same edge it changes
    grant_frame_n = (state_n == SCAN_FRAME);
    grant_reg_n   = (state_n == SCAN_REG);
  end

  // State register, scan counters, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      digit       <= '0;
      presc       <= '0;
      snap        <= '0;
      last_reg    <= 1'b1;
      grant_frame <= 1'b0;
      grant_reg   <= 1'b0;
      frame_done  <= 1'b0;
      pos         <= DISP_OFF;
      segments    <= DISP_OFF;
    end else begin
      state       <= state_n;
      digit       <= digit_n;
      presc       <= presc_n;
      snap        <= snap_n;
      last_reg    <= last_reg_n;
      grant_frame <= grant_frame_n;
      grant_reg   <= grant_reg_n;
      frame_done  <= frame_done_n;
      pos         <= pos_n;
      segments    <= segments_n;
    end
  end

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Bench for ssd_scan_arbiter with CLK_DIV=4, BLANK_CYCLES=1. A frame-level
// model (owner, cycle-in-frame, snapshot, last winner) predicts every output
// each cycle; directed literal checks pin the model at key moments.
module tb_ssd_scan_arbiter;

  localparam int CD = 4;
  localparam int BC = 1;
  localparam int FRAME_LEN = 8 * CD;

  logic        clk;
  logic        rst;
  logic        frame_req;
  logic [31:0] frame_data;
  logic        reg_req;
  logic [31:0] reg_data;
  logic        grant_frame;
  logic        grant_reg;
  logic        frame_done;
  logic [7:0]  pos;
  logic [7:0]  segments;

  int checks = 0;
  int errors = 0;

  ssd_scan_arbiter #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_req  (frame_req),
    .frame_data (frame_data),
    .reg_req    (reg_req),
    .reg_data   (reg_data),
    .grant_frame(grant_frame),
    .grant_reg  (grant_reg),
    .frame_done (frame_done),
    .pos        (pos),
    .segments   (segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Model state: owner 0=none 1=frame 2=reg; m_t = cycle index within frame
  int          m_owner;
  int          m_t;
  logic [31:0] m_snap;
  logic        m_last_reg;
  int          m_d, m_ph, m_nxt;
  logic [7:0]  e_pos, e_seg;
  logic        e_gf, e_gr, e_done;

  // Frame-level reference model
  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_t = 0; m_snap = 32'h0; m_last_reg = 1'b1;
      e_pos = 8'hFF; e_seg = 8'hFF; e_gf = 1'b0; e_gr = 1'b0; e_done = 1'b0;
    end else begin
      m_d  = m_t / CD;
      m_ph = m_t % CD;
      if (m_owner == 0 || m_ph < BC) begin
        e_pos = 8'hFF;
        e_seg = 8'hFF;
      end else begin
        e_pos = ~(8'(1) << m_d);
        e_seg = glyph(4'(m_snap >> (4 * m_d)));
`ifdef SSD_SRC_MARK_EN
        if (m_owner == 2 && m_d == 7) e_seg[7] = 1'b0;
`endif
      end
      e_done = (m_owner != 0) && (m_t == FRAME_LEN - 1);
      if (m_owner == 0 || m_t == FRAME_LEN - 1) begin
        if (frame_req && reg_req) m_nxt = m_last_reg ? 1 : 2;
        else if (frame_req)       m_nxt = 1;
        else if (reg_req)         m_nxt = 2;
        else                      m_nxt = 0;
        if (m_nxt != 0) begin
          m_snap     = (m_nxt == 1) ? frame_data : reg_data;
          m_last_reg = (m_nxt == 2);
        end
        m_owner = m_nxt;
        m_t     = 0;
      end else begin
        m_t = m_t + 1;
      end
      e_gf = (m_owner == 1);
      e_gr = (m_owner == 2);
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    check("pos", pos, e_pos);
    check("segments", segments, e_seg);
    check("grant_frame", grant_frame, e_gf);
    check("grant_reg", grant_reg, e_gr);
    check("frame_done", frame_done, e_done);
    check("grant_exclusive", grant_frame & grant_reg, 1'b0);
  end

  initial begin
    rst = 1'b1; frame_req = 1'b0; reg_req = 1'b0;
    frame_data = 32'h0; reg_data = 32'h0;
    repeat (5) @(negedge clk);
    check("rst_pos", pos, 8'hFF);
    check("rst_seg", segments, 8'hFF);
    check("rst_gf", grant_frame, 1'b0);
    check("rst_gr", grant_reg, 1'b0);
    check("rst_done", frame_done, 1'b0);

    // Single frame requester
    rst = 1'b0; frame_req = 1'b1; frame_data = 32'h76543210;
    @(posedge clk); #1; check("lit_gf_rise", grant_frame, 1'b1);          // P1
    @(posedge clk); #1; check("lit_d0_blank", pos, 8'hFF);                // P2
    @(posedge clk); #1; check("lit_d0_pos", pos, 8'hFE);                  // P3
    check("lit_d0_seg", segments, 8'hC0);
    repeat (4) @(posedge clk); #1;                                        // P7
    check("lit_d1_pos", pos, 8'hFD);
    check("lit_d1_seg", segments, 8'hF9);
    repeat (26) @(posedge clk); #1; check("lit_done1", frame_done, 1'b1); // P33
    repeat (32) @(posedge clk); #1; check("lit_done2", frame_done, 1'b1); // P65

    // Data change during digit 3 stays invisible until the next frame
    repeat (13) @(posedge clk);                                           // P78
    @(negedge clk); frame_data = 32'hFFFFFFFF;
    repeat (5) @(posedge clk); #1;                                        // P83
    check("lit_old_snap_pos", pos, 8'hEF);
    check("lit_old_snap_seg", segments, 8'h99);
    repeat (16) @(posedge clk); #1;                                       // P99
    check("lit_new_snap_seg", segments, 8'h8E);

    // Drop request at digit 2; frame completes then goes idle
    repeat (6) @(posedge clk);                                            // P105
    @(negedge clk); frame_req = 1'b0;
    repeat (24) @(posedge clk); #1;                                       // P129
    check("lit_drop_done", frame_done, 1'b1);
    check("lit_drop_gf", grant_frame, 1'b0);
    @(posedge clk); #1; check("lit_idle_pos", pos, 8'hFF);                // P130

    // Tie from reset: frame first, then reg
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    frame_req = 1'b1; reg_req = 1'b1;
    frame_data = 32'h11111111; reg_data = 32'hAAAAAAAA;
    @(posedge clk); #1; check("lit_tie_gf", grant_frame, 1'b1);           // P1
    check("lit_tie_gr", grant_reg, 1'b0);
    repeat (2) @(posedge clk); #1; check("lit_tie_seg1", segments, 8'hF9); // P3
    repeat (30) @(posedge clk); #1;                                       // P33
    check("lit_rr_gr", grant_reg, 1'b1);
    check("lit_rr_gf", grant_frame, 1'b0);
    repeat (2) @(posedge clk); #1; check("lit_rr_seg", segments, 8'h88);  // P35

    // Reset during reg frame digit 5
    repeat (19) @(posedge clk);                                           // P54
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;                                                   // P55
    check("lit_midrst_pos", pos, 8'hFF);
    check("lit_midrst_seg", segments, 8'hFF);
    check("lit_midrst_gr", grant_reg, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) frame_req = ~frame_req;
      if ($urandom_range(15) == 0) reg_req = ~reg_req;
      if ($urandom_range(7) == 0) frame_data = $urandom;
      if ($urandom_range(7) == 0) reg_data = $urandom;
      rst = ($urandom_range(699) == 0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
